// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : capture_pkg
//  Description : Shared state encoding and default widths for sample_capture.
//  Revision    : 1.0  initial release
// ============================================================================
package capture_pkg;

  // Default sample width (matches the upstream sine generator output)
  localparam int c_D_WIDTH = 8;
  // Default capture buffer address width (DEPTH = 2**A_WIDTH)
  localparam int c_A_WIDTH = 8;

  // Capture controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram2port.sv
`default_nettype none
// ============================================================================
//  Module      : ram2port
//  Description : DEPTH x D_WIDTH simple dual-port RAM, one synchronous write
//                port and one synchronous read port with 1-cycle latency.
//                The read register holds its value when no read is issued.
//  Revision    : 1.0  initial release
// ============================================================================
module ram2port
  import capture_pkg::*;
#(
  parameter int D_WIDTH = c_D_WIDTH,
  parameter int A_WIDTH = c_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  localparam int c_DEPTH = 2 ** A_WIDTH;

  logic [D_WIDTH-1:0] r_mem [0:c_DEPTH-1];

  // Write port: storage array is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read port: registered output, cleared by reset, held between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= r_mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_capture.sv
`default_nettype none
// ============================================================================
//  Module      : sample_capture
//  Description : Rising-edge triggered capture of DEPTH en-qualified samples
//                into a buffer, followed by random-access readout.
//                Index 0 of the buffer always holds the trigger sample.
//  Revision    : 1.0  initial release
// ============================================================================
module sample_capture
  import capture_pkg::*;
#(
  parameter int D_WIDTH = c_D_WIDTH,
  parameter int A_WIDTH = c_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic               arm,
  input  logic [D_WIDTH-1:0] trig_level,
  input  logic               rd_en,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               rd_valid
);

  state_t             r_state;
  logic [A_WIDTH-1:0] r_wr_ptr;
  logic [D_WIDTH-1:0] r_prev;
  logic               r_prev_valid;

  logic               w_trigger;
  logic               w_we;
  logic [A_WIDTH-1:0] w_waddr;
  logic               w_re;
  logic               w_last;

  // Rising crossing: previous sample strictly below the level, current at or above
  assign w_trigger = en && r_prev_valid && (r_state == ST_ARMED)
                     && (r_prev < trig_level) && (din >= trig_level);

  // arm takes priority over any write or read in the same cycle
  assign w_we    = !arm && (w_trigger || ((r_state == ST_CAPTURE) && en));
  assign w_waddr = (r_state == ST_CAPTURE) ? r_wr_ptr : '0;
  assign w_re    = !arm && rd_en && (r_state == ST_DONE);
  assign w_last  = (r_wr_ptr == {A_WIDTH{1'b1}});

  // Capture controller with registered status flags and read-valid strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      armed        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= w_re;
      if (arm) begin
        r_state      <= ST_ARMED;
        r_wr_ptr     <= '0;
        r_prev_valid <= 1'b0;
        armed        <= 1'b1;
        busy         <= 1'b0;
        done         <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_ARMED: begin
            if (en) begin
              r_prev       <= din;
              r_prev_valid <= 1'b1;
              if (w_trigger) begin
                r_state  <= ST_CAPTURE;
                r_wr_ptr <= A_WIDTH'(1);
                armed    <= 1'b0;
                busy     <= 1'b1;
              end
            end
          end
          ST_CAPTURE: begin
            // Stop on the last address instead of wrapping over the trigger sample
            if (en) begin
              if (w_last) begin
                r_state <= ST_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                r_wr_ptr <= r_wr_ptr + A_WIDTH'(1);
              end
            end
          end
          ST_DONE: begin
          end
          default: begin
            r_state <= ST_IDLE;
            armed   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

  ram2port #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (din),
    .re    (w_re),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_sample_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sample_capture
//  Description : Self-checking bench for sample_capture (A_WIDTH=4, 16 deep).
//                A queue-based reference model predicts the outputs on every
//                cycle; directed sequences pin the model with literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sample_capture;

  localparam int D_WIDTH = 8;
  localparam int A_WIDTH = 4;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic [D_WIDTH-1:0] din = '0;
  logic               arm = 1'b0;
  logic [D_WIDTH-1:0] trig_level = '0;
  logic               rd_en = 1'b0;
  logic [A_WIDTH-1:0] rd_addr = '0;
  logic               armed, busy, done, rd_valid;
  logic [D_WIDTH-1:0] rd_data;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  sample_capture #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .arm        (arm),
    .trig_level (trig_level),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .armed      (armed),
    .busy       (busy),
    .done       (done),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Status is tracked as "waiting for trigger / collecting / complete" and the
  // capture itself is a queue; the readable buffer image is the completed queue.
  bit               m_armed, m_busy, m_done, m_rd_valid, m_prev_valid;
  logic [7:0]       m_rd_data, m_prev;
  logic [7:0]       m_cap[$];
  logic [7:0]       m_mem[DEPTH];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_armed = 0; m_busy = 0; m_done = 0; m_rd_valid = 0; m_prev_valid = 0;
      m_rd_data = 0; m_prev = 0;
      m_cap.delete();
    end else begin
      m_rd_valid = 0;
      if (arm) begin
        m_armed = 1; m_busy = 0; m_done = 0; m_prev_valid = 0;
        m_cap.delete();
      end else if (m_armed) begin
        if (en) begin
          if (m_prev_valid && (m_prev < trig_level) && (din >= trig_level)) begin
            m_cap.push_back(din);
            m_armed = 0;
            m_busy  = 1;
          end
          m_prev = din;
          m_prev_valid = 1;
        end
      end else if (m_busy) begin
        if (en) begin
          m_cap.push_back(din);
          if (m_cap.size() == DEPTH) begin
            m_busy = 0;
            m_done = 1;
            foreach (m_cap[i]) m_mem[i] = m_cap[i];
          end
        end
      end else if (m_done && rd_en) begin
        m_rd_data  = m_mem[rd_addr];
        m_rd_valid = 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_armed",    armed,    m_armed);
      chk("cyc_busy",     busy,     m_busy);
      chk("cyc_done",     done,     m_done);
      chk("cyc_rd_valid", rd_valid, m_rd_valid);
      chk("cyc_rd_data",  rd_data,  m_rd_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input bit a, input bit e, input logic [7:0] d,
                     input bit r, input logic [3:0] ra);
    arm = a; en = e; din = d; rd_en = r; rd_addr = ra;
    cyc();
  endtask

  function automatic logic [7:0] sine(input int ph);
    real v;
    v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(ph) / 256.0);
    return 8'($rtoi(v));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1;
    int         ph;
    bit         do_rst;

    // Power-on reset across several edges
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    cmp_on = 1'b1;

    // Reset state
    chk("rst_armed",    armed,    0);
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data",  rd_data,  0);

    // Trigger on the rising crossing at 0x80
    trig_level = 8'h80;
    put(1, 0, 8'h00, 0, 0);
    chk("trig_armed", armed, 1);
    put(0, 1, 8'h7E, 0, 0);
    put(0, 1, 8'h7F, 0, 0);
    chk("trig_not_yet", busy, 0);
    put(0, 1, 8'h80, 0, 0);
    chk("trig_busy", busy, 1);
    chk("trig_armed_low", armed, 0);
    for (int i = 1; i < DEPTH; i++) put(0, 1, 8'(8'h80 + i), 0, 0);
    chk("trig_done", done, 1);
    put(0, 0, 8'h00, 1, 0);
    chk("trig_buf0_valid", rd_valid, 1);
    chk("trig_buf0", rd_data, 8'h80);
    put(0, 0, 8'h00, 1, 1);
    chk("trig_buf1", rd_data, 8'h81);
    put(0, 0, 8'h00, 0, 0);
    chk("hold_rd_valid", rd_valid, 0);
    chk("hold_rd_data", rd_data, 8'h81);

    // No false trigger: first sample above, then falling
    put(1, 0, 8'h00, 0, 0);
    put(0, 1, 8'h90, 0, 0);
    put(0, 1, 8'h70, 0, 0);
    put(0, 1, 8'h60, 0, 0);
    put(0, 1, 8'h70, 0, 0);
    put(0, 1, 8'h70, 0, 0);
    chk("nofalse_armed", armed, 1);
    chk("nofalse_busy", busy, 0);

    // Full capture with en on alternate cycles; done after exactly 16 writes
    put(1, 0, 8'h00, 0, 0);
    put(0, 1, 8'h10, 0, 0);
    put(0, 1, 8'h40, 0, 0);
    put(0, 1, 8'h80, 0, 0);
    for (int i = 1; i < DEPTH - 1; i++) begin
      put(0, 0, 8'hAA, 0, 0);
      put(0, 1, 8'(8'h80 + i), 0, 0);
    end
    chk("alt_15_writes_done", done, 0);
    chk("alt_15_writes_busy", busy, 1);
    put(0, 0, 8'hAA, 0, 0);
    chk("alt_gap_busy", busy, 1);
    put(0, 1, 8'h8F, 0, 0);
    chk("alt_16_writes_done", done, 1);
    for (int k = 0; k < DEPTH; k++) begin
      put(0, 0, 8'h00, 1, 4'(k));
      chk("ramp_rd_valid", rd_valid, 1);
      chk("ramp_rd_data", rd_data, 32'(8'h80 + k));
    end
    // arm beats rd_en
    put(1, 0, 8'h00, 1, 3);
    chk("armrd_rd_valid", rd_valid, 0);
    chk("armrd_armed", armed, 1);
    chk("armrd_rd_data", rd_data, 8'h8F);

    // Abort at write pointer 5, then restart from address 0
    put(0, 1, 8'h20, 0, 0);
    put(0, 1, 8'hA0, 0, 0);
    for (int i = 1; i < 5; i++) put(0, 1, 8'(8'hA0 + i), 0, 0);
    put(1, 0, 8'h00, 0, 0);
    chk("abort_armed", armed, 1);
    chk("abort_busy", busy, 0);
    put(0, 1, 8'h10, 0, 0);
    put(0, 1, 8'hC0, 0, 0);
    for (int i = 1; i < DEPTH; i++) put(0, 1, 8'(8'hC0 + i), 0, 0);
    chk("abort_done", done, 1);
    put(0, 0, 8'h00, 1, 0);
    chk("abort_buf0", rd_data, 8'hC0);
    put(0, 0, 8'h00, 1, 5);
    chk("abort_buf5", rd_data, 8'hC5);

    // Reset held mid-capture
    put(1, 0, 8'h00, 0, 0);
    put(0, 1, 8'h10, 0, 0);
    put(0, 1, 8'h90, 0, 0);
    put(0, 1, 8'h91, 0, 0);
    chk("midrst_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy",     busy,     0);
    chk("midrst_armed",    armed,    0);
    chk("midrst_done",     done,     0);
    chk("midrst_rd_data",  rd_data,  0);
    chk("midrst_rd_valid", rd_valid, 0);
    cyc();
    cyc();
    #2 rst = 1'b1;
    put(0, 0, 8'h00, 1, 0);
    put(0, 0, 8'h00, 1, 1);
    chk("postrst_rd_valid", rd_valid, 0);
    chk("postrst_rd_data",  rd_data,  0);
    put(0, 1, 8'h10, 0, 0);
    put(0, 1, 8'h90, 0, 0);
    chk("postrst_busy",  busy,  0);
    chk("postrst_armed", armed, 0);

    // End-to-end from a sine source, phase increment 4
    trig_level = 8'h80;
    put(1, 0, 8'h00, 0, 0);
    ph = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      put(0, 1, sine(ph), 0, 0);
      ph = (ph + 4) % 256;
    end
    chk("e2e_done", done, 1);
    put(0, 0, 8'h00, 1, 0);
    b0 = rd_data;
    put(0, 0, 8'h00, 1, 1);
    b1 = rd_data;
    chk("e2e_b0_ge_80", 32'(b0 >= 8'h80), 1);
    chk("e2e_b1_gt_b0", 32'(b1 > b0), 1);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) trig_level = 8'($urandom);
      do_rst = ($urandom_range(0, 699) == 0);
      if (do_rst) #2 rst = 1'b0;
      put((i == 0) || ($urandom_range(0, 149) == 0), 1'($urandom), 8'($urandom),
          1'($urandom), 4'($urandom));
      if (do_rst) #2 rst = 1'b1;
    end
    put(0, 0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter D_WIDTH, default 8: sample width in bits, equal to the generator dout width.
REQ-002 Parameter A_WIDTH, default 8: capture buffer address width; DEPTH = 2**A_WIDTH samples.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately regardless of clk.
REQ-005 en  input  1  sample strobe; din is valid in a cycle when en=1.
REQ-006 din  input  D_WIDTH  unsigned sample from the upstream sine generator dout.
REQ-007 arm  input  1  single-cycle request to start a new capture.
REQ-008 trig_level  input  D_WIDTH  unsigned rising-edge trigger threshold.
REQ-009 rd_en  input  1  readout request, accepted only in DONE.
REQ-010 rd_addr  input  A_WIDTH  buffer index to read; index 0 is the trigger sample.
REQ-011 armed  output  1  high in state ARMED.
REQ-012 busy  output  1  high in state CAPTURE.
REQ-013 done  output  1  high in state DONE.
REQ-014 rd_data  output  D_WIDTH  sample read from the buffer.
REQ-015 rd_valid  output  1  high for one cycle when rd_data holds a newly read sample.

Function
REQ-016 The block SHALL implement the states IDLE, ARMED, CAPTURE and DONE.
REQ-017 arm=1 in any state SHALL move to ARMED on the next edge, clearing the write pointer, prev_valid and done; this aborts any capture in progress.
REQ-018 In ARMED, each en=1 cycle SHALL latch din into prev and set prev_valid.
REQ-019 In ARMED, trigger = en & prev_valid & (prev < trig_level) & (din >= trig_level), using an unsigned compare.
REQ-020 On trigger, the block SHALL write din to address 0, set the write pointer to 1 and enter CAPTURE on the same edge.
REQ-021 In CAPTURE, each en=1 cycle SHALL write din at the write pointer and increment it; en=0 cycles SHALL write nothing.
REQ-022 When the write at address DEPTH-1 completes, the block SHALL enter DONE; the pointer SHALL NOT wrap into already-captured data.
REQ-023 A capture SHALL contain exactly DEPTH samples, which are the trigger sample plus the next DEPTH-1 en-qualified samples.
REQ-024 In DONE, rd_en=1 SHALL produce rd_data=buffer[rd_addr] with rd_valid=1 exactly one cycle later; back-to-back reads SHALL be supported at one per cycle.
REQ-025 rd_en outside DONE SHALL be ignored: rd_valid stays 0 and rd_data holds its last value.
REQ-026 If arm and rd_en are high in the same cycle, arm SHALL win; no rd_valid is produced.
REQ-027 The block SHALL stay in DONE until the next arm; en and din are ignored in IDLE and DONE.
REQ-028 A sample equal to trig_level with prev also >= trig_level SHALL NOT trigger; a flat or falling input never triggers.
REQ-029 armed, busy and done SHALL be registered, mutually exclusive, and all 0 in IDLE.

Reset
REQ-030 rst=0 SHALL force IDLE, write pointer 0, prev 0, prev_valid 0, rd_data 0, rd_valid 0 and armed, busy, done 0.
REQ-031 Buffer contents are not reset; rst asserted mid-capture SHALL abandon the capture, and a DONE state is only reached by a fresh arm.

Structure
REQ-032 The state enum and default D_WIDTH and A_WIDTH constants SHALL live in the shared package capture_pkg.
REQ-033 Storage SHALL be one sub-module, ram2port: one synchronous write port and one synchronous read port (1-cycle latency), DEPTH x D_WIDTH.

Verification
REQ-034 Reset: hold rst=0 mid-CAPTURE, then release -> all outputs 0, state IDLE, rd_en is ignored.
REQ-035 Trigger: trig_level=8'h80, arm, then feed en=1 with din 7E,7F,80,81 -> trigger on 80, buffer[0]=80, buffer[1]=81, busy=1.
REQ-036 No false trigger: din starts at 90 after arm (first sample), then falls to 70 -> armed stays 1 and busy stays 0.
REQ-037 Full capture, A_WIDTH=4: after trigger, apply en on alternate cycles -> done rises after exactly 16 writes, and reads of addr 0..15 return the written ramp 1 cycle after each rd_en.
REQ-038 Abort: arm during CAPTURE at pointer 5 -> armed=1, busy=0 next cycle, and the following capture starts again at address 0.
REQ-039 End-to-end: drive from the sinegen dout with incr=4 and trig_level=8'h80 -> buffer[0] >= 80 and buffer[1] > buffer[0].
